// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register-file bus transfer sequencer (MOV/LDI/RD/NOP)
// Optional transfer counter output xfer_count enabled by macro BUS_XFER_COUNT_EN.
module bus_xfer_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_src,
   input  logic [1:0]  cmd_dst,
   input  logic [7:0]  cmd_imm,
   output logic        load,
   output logic        enable,
   output logic [1:0]  in_regselect,
   output logic [1:0]  out_regselect,
   input  logic [7:0]  bus_in,
   output logic [7:0]  bus_out,
   output logic        bus_drive,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_data,
`ifdef BUS_XFER_COUNT_EN
   output logic [15:0] xfer_count,
`endif
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_RESP = 2'd2} state_t;

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  src_q, src_d;
   logic [1:0]  dst_q, dst_d;
   logic [7:0]  imm_q, imm_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        cmd_hs;

   assign cmd_hs = cmd_valid && (state_q == S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= 2'b00;
         src_q      <= 2'b00;
         dst_q      <= 2'b00;
         imm_q      <= 8'h00;
         rsp_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         imm_q      <= imm_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_d      = src_q;
      dst_d      = dst_q;
      imm_d      = imm_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_hs) begin
               op_d  = cmd_op;
               src_d = cmd_src;
               dst_d = cmd_dst;
               imm_d = cmd_imm;
               if (cmd_op != OP_NOP) state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (op_q == OP_RD) begin
               rsp_data_d = bus_in;
               state_d    = S_RESP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Every output is forced low while reset is high so an aborted XFER never issues a load.
   always_comb begin
      cmd_ready     = 1'b0;
      load          = 1'b0;
      enable        = 1'b0;
      bus_drive     = 1'b0;
      rsp_valid     = 1'b0;
      busy          = 1'b0;
      in_regselect  = 2'b00;
      out_regselect = 2'b00;
      bus_out       = 8'h00;
      rsp_data      = 8'h00;
      if (!reset) begin
         in_regselect  = dst_q;
         out_regselect = src_q;
         bus_out       = imm_q;
         rsp_data      = rsp_data_q;
         busy          = (state_q != S_IDLE);
         case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_XFER: begin
               case (op_q)
                  OP_MOV: begin
                     enable = 1'b1;
                     load   = 1'b1;
                  end
                  OP_LDI: begin
                     bus_drive = 1'b1;
                     load      = 1'b1;
                  end
                  OP_RD:   enable = 1'b1;
                  default: ;
               endcase
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef BUS_XFER_COUNT_EN
   logic [15:0] xfer_count_q, xfer_count_d;

   always_ff @(posedge clock) begin
      if (reset) xfer_count_q <= 16'h0000;
      else       xfer_count_q <= xfer_count_d;
   end

   always_comb begin
      xfer_count_d = xfer_count_q;
      if (state_q == S_XFER && xfer_count_q != 16'hFFFF)
         xfer_count_d = xfer_count_q + 16'h0001;
   end

   assign xfer_count = xfer_count_q;
`endif

endmodule
